// File: rtl/router_pkt_gen.sv
// Packet source for the 1x3 router: buffers payload bytes and sends header, payload and parity.
// Optional build macro ROUTER_PKT_GEN_ERRINJ_EN adds inj_err_i to corrupt bit 0 of the parity byte.
module router_pkt_gen #(
    parameter int MAX_LEN = 63
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       start_i,
    input  logic [1:0] dest_addr_i,
    input  logic       busy_i,
`ifdef ROUTER_PKT_GEN_ERRINJ_EN
    input  logic       inj_err_i,
`endif
    output logic [7:0] pkt_data_o,
    output logic       pkt_valid_o,
    output logic       idle_o,
    output logic [5:0] count_o,
    output logic       buf_full_o,
    output logic       done_o,
    output logic       req_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY} state_t;

    state_t     state_q;
    logic [7:0] buf_q [MAX_LEN];
    logic [5:0] count_q;
    logic [5:0] idx_q;
    logic [7:0] parity_q;
    logic [7:0] pkt_data_q;
    logic       pkt_valid_q;
    logic       idle_q;
    logic       buf_full_q;
    logic       done_q;
    logic       req_err_q;

    logic       start_acc_s;
    logic       wr_s;
    logic [5:0] idx_nxt_s;
    logic [7:0] par_out_s;

    function automatic logic [7:0] par_acc(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

`ifdef ROUTER_PKT_GEN_ERRINJ_EN
    logic inj_q;

    // Error-injection request captured with an accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inj_q <= 1'b0;
        end else if (start_acc_s) begin
            inj_q <= inj_err_i;
        end
    end
`endif

    // Start is judged on the pre-write count, so a write coinciding with start is dropped.
    always_comb begin
        start_acc_s = (state_q == S_IDLE) && start_i && (dest_addr_i != 2'd3) && (count_q != 6'd0);
        wr_s        = (state_q == S_IDLE) && wr_en_i && !start_i && !buf_full_q;
        idx_nxt_s   = idx_q + 6'd1;
`ifdef ROUTER_PKT_GEN_ERRINJ_EN
        par_out_s   = parity_q ^ {7'd0, inj_q};
`else
        par_out_s   = parity_q;
`endif
    end

    // Payload storage; contents are don't-care once count clears.
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            buf_q[count_q] <= wr_data_i;
        end
    end

    // Transmit FSM; parity accumulates only when a new byte is loaded, never on a held byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            count_q     <= 6'd0;
            idx_q       <= 6'd0;
            parity_q    <= 8'd0;
            pkt_data_q  <= 8'd0;
            pkt_valid_q <= 1'b0;
            idle_q      <= 1'b1;
            buf_full_q  <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            req_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_acc_s) begin
                        state_q     <= S_HEADER;
                        pkt_data_q  <= {count_q, dest_addr_i};
                        parity_q    <= {count_q, dest_addr_i};
                        pkt_valid_q <= 1'b1;
                        idle_q      <= 1'b0;
                    end else if (start_i) begin
                        req_err_q <= 1'b1;
                    end else if (wr_s) begin
                        count_q    <= count_q + 6'd1;
                        buf_full_q <= ((count_q + 6'd1) == 6'(MAX_LEN));
                    end
                end
                S_HEADER: begin
                    if (!busy_i) begin
                        state_q    <= S_PAYLOAD;
                        idx_q      <= 6'd0;
                        pkt_data_q <= buf_q[6'd0];
                        parity_q   <= par_acc(parity_q, buf_q[6'd0]);
                    end
                end
                S_PAYLOAD: begin
                    if (!busy_i) begin
                        if (idx_q == (count_q - 6'd1)) begin
                            state_q     <= S_PARITY;
                            pkt_valid_q <= 1'b0;
                            pkt_data_q  <= par_out_s;
                        end else begin
                            idx_q      <= idx_nxt_s;
                            pkt_data_q <= buf_q[idx_nxt_s];
                            parity_q   <= par_acc(parity_q, buf_q[idx_nxt_s]);
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy_i) begin
                        state_q    <= S_IDLE;
                        pkt_data_q <= 8'd0;
                        parity_q   <= 8'd0;
                        count_q    <= 6'd0;
                        buf_full_q <= 1'b0;
                        idle_q     <= 1'b1;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pkt_valid_q <= 1'b0;
                    pkt_data_q  <= 8'd0;
                    idle_q      <= 1'b1;
                end
            endcase
        end
    end

    assign pkt_data_o  = pkt_data_q;
    assign pkt_valid_o = pkt_valid_q;
    assign idle_o      = idle_q;
    assign count_o     = count_q;
    assign buf_full_o  = buf_full_q;
    assign done_o      = done_q;
    assign req_err_o   = req_err_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Scoreboard bench for router_pkt_gen: expected stream queued at start, popped by a byte monitor.
module tb_router_pkt_gen;
    localparam int MAX_LEN = 63;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [7:0] wr_data_i = 8'd0;
    logic       start_i = 1'b0;
    logic [1:0] dest_addr_i = 2'd0;
    logic       busy_i = 1'b0;
`ifdef ROUTER_PKT_GEN_ERRINJ_EN
    logic       inj_err_i = 1'b0;
`endif
    logic [7:0] pkt_data_o;
    logic       pkt_valid_o;
    logic       idle_o;
    logic [5:0] count_o;
    logic       buf_full_o;
    logic       done_o;
    logic       req_err_o;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [8:0] exp_q [$];
    logic [7:0] mbuf [64];
    int         mcount = 0;
    logic       m_inj = 1'b0;

    router_pkt_gen #(.MAX_LEN(MAX_LEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .start_i(start_i), .dest_addr_i(dest_addr_i), .busy_i(busy_i),
`ifdef ROUTER_PKT_GEN_ERRINJ_EN
        .inj_err_i(inj_err_i),
`endif
        .pkt_data_o(pkt_data_o), .pkt_valid_o(pkt_valid_o), .idle_o(idle_o),
        .count_o(count_o), .buf_full_o(buf_full_o), .done_o(done_o), .req_err_o(req_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Byte monitor: every non-idle cycle shows the queue head; it is consumed only when busy is low.
    always @(negedge clk_i) begin
        if (!rst_i && !idle_o) begin
            if (exp_q.size() == 0) begin
                chk("stream_unexpected", 32'({pkt_valid_o, pkt_data_o}), 32'h1ff);
            end else begin
                chk("stream", 32'({pkt_valid_o, pkt_data_o}), 32'(exp_q[0]));
                if (!busy_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        wr_en_i = 1'b1;
        wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
        if (mcount < MAX_LEN) begin
            mbuf[mcount] = d;
            mcount++;
        end
    endtask

    task automatic send(input logic [1:0] dest, input int stall_at, input int stall_len);
        logic [7:0] par;
        logic [5:0] c6;
        int cyc;
        c6 = 6'(mcount);
        par = {c6, dest};
        exp_q.push_back({1'b1, par});
        for (int i = 0; i < mcount; i++) begin
            exp_q.push_back({1'b1, mbuf[i]});
            par = par ^ mbuf[i];
        end
        exp_q.push_back({1'b0, par ^ {7'd0, m_inj}});
`ifdef ROUTER_PKT_GEN_ERRINJ_EN
        inj_err_i = m_inj;
`endif
        start_i = 1'b1;
        dest_addr_i = dest;
        tick();
        start_i = 1'b0;
        cyc = 0;
        busy_i = (1 >= stall_at) && (1 < stall_at + stall_len);
        while (!done_o && cyc < 300) begin
            tick();
            cyc++;
            busy_i = (cyc + 1 >= stall_at) && (cyc + 1 < stall_at + stall_len);
        end
        busy_i = 1'b0;
        chk("latency", 32'(cyc), 32'(mcount + 2 + stall_len));
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("idle_at_done", 32'(idle_o), 32'd1);
        chk("count_cleared", 32'(count_o), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done_o), 32'd0);
        mcount = 0;
        m_inj = 1'b0;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_pkt_data", 32'(pkt_data_o), 32'd0);
        chk("rst_pkt_valid", 32'(pkt_valid_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_buf_full", 32'(buf_full_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_req_err", 32'(req_err_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Basic three-byte packet to port 1.
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("count_after_wr", 32'(count_o), 32'd3);
        send(2'd1, 0, 0);

        // Same packet, busy held for 3 cycles while the second payload byte is presented.
        wr(8'h11); wr(8'h22); wr(8'h33);
        send(2'd1, 3, 3);

        // Rejected start on dest 3 with a simultaneous write that must be ignored.
        wr(8'h11); wr(8'h22); wr(8'h33);
        wr_en_i = 1'b1; wr_data_i = 8'h99; start_i = 1'b1; dest_addr_i = 2'd3;
        tick();
        wr_en_i = 1'b0; start_i = 1'b0;
        chk("rej3_req_err", 32'(req_err_o), 32'd1);
        chk("rej3_valid", 32'(pkt_valid_o), 32'd0);
        chk("rej3_idle", 32'(idle_o), 32'd1);
        chk("rej3_count", 32'(count_o), 32'd3);
        tick();
        chk("rej3_req_err_clr", 32'(req_err_o), 32'd0);
        send(2'd2, 0, 0);

        // Rejected start on an empty buffer.
        start_i = 1'b1; dest_addr_i = 2'd1;
        tick();
        start_i = 1'b0;
        chk("rej0_req_err", 32'(req_err_o), 32'd1);
        chk("rej0_valid", 32'(pkt_valid_o), 32'd0);
        tick();
        chk("rej0_req_err_clr", 32'(req_err_o), 32'd0);
        chk("rej0_idle", 32'(idle_o), 32'd1);

        // Fill past capacity: the 64th byte is dropped, then a full-length packet to port 2.
        for (int i = 0; i < 64; i++) begin
            wr(8'((i * 5 + 7) % 256));
            if (i == 61) chk("not_full_62", 32'(buf_full_o), 32'd0);
        end
        chk("full_count", 32'(count_o), 32'd63);
        chk("full_flag", 32'(buf_full_o), 32'd1);
        send(2'd2, 0, 0);

        // Asynchronous reset during the payload phase.
        wr(8'h11); wr(8'h22); wr(8'h33);
        exp_q.push_back({1'b1, 8'h0D});
        exp_q.push_back({1'b1, 8'h11});
        start_i = 1'b1; dest_addr_i = 2'd1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        #1 rst_i = 1'b1;
        #1;
        chk("arst_pkt_valid", 32'(pkt_valid_o), 32'd0);
        chk("arst_pkt_data", 32'(pkt_data_o), 32'd0);
        chk("arst_idle", 32'(idle_o), 32'd1);
        chk("arst_count", 32'(count_o), 32'd0);
        #1 rst_i = 1'b0;
        chk("arst_prefix_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        mcount = 0;
        tick();
        wr(8'hA5); wr(8'h5A); wr(8'h3C);
        send(2'd0, 0, 0);

`ifdef ROUTER_PKT_GEN_ERRINJ_EN
        wr(8'h11); wr(8'h22); wr(8'h33);
        m_inj = 1'b1;
        send(2'd1, 0, 0);
        inj_err_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
